vision_test_ctrl: RTL and testbench



---
 rtl/vision_pkg.sv | 27 ++
 rtl/key_edge.sv | 25 ++
 rtl/vision_test_ctrl.sv | 177 +++++++++++++++++
 tb/tb_vision_test_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared constants and state encoding for the acuity tester
package vision_pkg;

    // Level indices: 0.1, 0.2, 0.4, 0.6, 0.8, 1.0, 1.2
    localparam logic [2:0] L_0P1     = 3'd0;
    localparam logic [2:0] L_0P2     = 3'd1;
    localparam logic [2:0] L_0P4     = 3'd2;
    localparam logic [2:0] L_0P6     = 3'd3;
    localparam logic [2:0] L_0P8     = 3'd4;
    localparam logic [2:0] L_1P0     = 3'd5;
    localparam logic [2:0] L_1P2     = 3'd6;
    localparam logic [2:0] MAX_LEVEL = L_1P2;

    // Optotype direction codes, also the bit index of the matching answer key
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - two-flop key register with rising-edge detect
module key_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_rise
);

    logic r_s;
    logic r_q;

    // Sample the key, then delay it one more cycle for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s <= 1'b0;
            r_q <= 1'b0;
        end else begin
            r_s <= i_key;
            r_q <= r_s;
        end
    end

    assign o_rise = r_s & ~r_q;

endmodule

// File: rtl/vision_test_ctrl.sv
// rtl/vision_test_ctrl.sv - visual-acuity test sequencer (keys in, level/dir/result out)
module vision_test_ctrl
    import vision_pkg::*;
#(
    parameter int         START_LEVEL = 4,
    parameter int         BLANK_CYC   = 1000,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_restart,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic       show,
    output logic [1:0] dir,
    output logic [2:0] level,
    output logic       done,
    output logic       fail,
    output logic [2:0] result,
    output logic       ans_ok,
    output logic       ans_err
);

    localparam int CNT_MAX = (BLANK_CYC > TIMEOUT_CYC) ? BLANK_CYC : TIMEOUT_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    START_LVL    = 3'(START_LEVEL);

    // Bit order matches the direction codes; bit 4 is restart
    logic [4:0] w_keys;
    logic [4:0] w_rise;
    logic [3:0] w_ans;
    logic       w_one_ans;
    logic       w_correct;
    logic       w_wrong;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_lfsr;
    logic          r_show;
    logic [1:0]    r_dir;
    logic [2:0]    r_level;
    logic          r_went_up;
    logic          r_went_down;
    logic          r_done;
    logic          r_fail;
    logic [2:0]    r_result;
    logic          r_ans_ok;
    logic          r_ans_err;

    assign w_keys = {key_restart, key_right, key_left, key_down, key_up};

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_key
            key_edge u_key_edge (
                .i_clk  (sys_clk),
                .i_rst  (sys_rst),
                .i_key  (w_keys[g]),
                .o_rise (w_rise[g])
            );
        end
    endgenerate

    // A single answer-key rise is an answer; simultaneous rises are discarded
    assign w_ans     = w_rise[3:0];
    assign w_one_ans = (w_ans != 4'd0) && ((w_ans & (w_ans - 4'd1)) == 4'd0);
    assign w_correct = w_one_ans && w_ans[r_dir];
    assign w_wrong   = w_one_ans ? !w_ans[r_dir] : (r_cnt == TIMEOUT_LAST);

    // Free-running Fibonacci LFSR, taps 8,6,5,4, supplies the next direction
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // Test sequencer: blanking, stimulus, answer grading and level staircase
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_show      <= 1'b0;
            r_dir       <= DIR_UP;
            r_level     <= START_LVL;
            r_went_up   <= 1'b0;
            r_went_down <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_result    <= 3'd0;
            r_ans_ok    <= 1'b0;
            r_ans_err   <= 1'b0;
        end else begin
            r_ans_ok  <= 1'b0;
            r_ans_err <= 1'b0;
            if (w_rise[4]) begin
                r_state     <= ST_BLANK;
                r_cnt       <= '0;
                r_show      <= 1'b0;
                r_level     <= START_LVL;
                r_went_up   <= 1'b0;
                r_went_down <= 1'b0;
                r_done      <= 1'b0;
                r_fail      <= 1'b0;
                r_result    <= 3'd0;
            end else begin
                case (r_state)
                    ST_BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= ST_SHOW;
                            r_cnt   <= '0;
                            r_show  <= 1'b1;
                            r_dir   <= r_lfsr[1:0];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (w_correct) begin
                            r_ans_ok <= 1'b1;
                            r_show   <= 1'b0;
                            r_cnt    <= '0;
                            if (r_went_down || (r_level == MAX_LEVEL)) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_result <= r_level;
                            end else begin
                                r_state   <= ST_BLANK;
                                r_level   <= r_level + 3'd1;
                                r_went_up <= 1'b1;
                            end
                        end else if (w_wrong) begin
                            r_ans_err <= 1'b1;
                            r_show    <= 1'b0;
                            r_cnt     <= '0;
                            if (r_went_up) begin
                                r_state  <= ST_DONE;
                                r_done   <= 1'b1;
                                r_result <= r_level - 3'd1;
                            end else if (r_level == L_0P1) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state     <= ST_BLANK;
                                r_level     <= r_level - 3'd1;
                                r_went_down <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until a restart rise
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign show    = r_show;
    assign dir     = r_dir;
    assign level   = r_level;
    assign done    = r_done;
    assign fail    = r_fail;
    assign result  = r_result;
    assign ans_ok  = r_ans_ok;
    assign ans_err = r_ans_err;

endmodule

// File: tb/tb_vision_test_ctrl.sv
// tb/tb_vision_test_ctrl.sv - scoreboard bench for vision_test_ctrl
module tb_vision_test_ctrl;

    localparam int         BLANK = 4;
    localparam int         TO    = 50;
    localparam int         START = 4;
    localparam logic [7:0] SEED  = 8'hA5;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_restart = 1'b0;
    logic [3:0] keys = 4'd0;
    logic       show;
    logic [1:0] dir;
    logic [2:0] level;
    logic       done;
    logic       fail;
    logic [2:0] result;
    logic       ans_ok;
    logic       ans_err;

    always #5 sys_clk = ~sys_clk;

    vision_test_ctrl #(
        .START_LEVEL (START),
        .BLANK_CYC   (BLANK),
        .TIMEOUT_CYC (TO),
        .LFSR_SEED   (SEED)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_restart (key_restart),
        .key_up      (keys[0]),
        .key_down    (keys[1]),
        .key_left    (keys[2]),
        .key_right   (keys[3]),
        .show        (show),
        .dir         (dir),
        .level       (level),
        .done        (done),
        .fail        (fail),
        .result      (result),
        .ans_ok      (ans_ok),
        .ans_err     (ans_err)
    );

    typedef struct packed {
        logic       ok;
        logic [2:0] lvl;
        logic       dn;
        logic       fl;
        logic [2:0] res;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int  m_level;
    bit  m_up, m_down, m_done, m_fail;
    int  m_result;
    logic [7:0] m_lfsr = SEED;
    logic [7:0] m_prev = SEED;
    logic       prev_show = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Direction source model: the spec's 8-bit LFSR stepped once per clock
    always @(posedge sys_clk) begin
        m_prev = m_lfsr;
        if (sys_rst) m_lfsr = SEED;
        else         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Monitor: every answer pulse consumes one scoreboard entry
    always @(negedge sys_clk) begin
        if (!sys_rst && (ans_ok || ans_err)) begin
            if (sb.size() == 0) begin
                check("spurious_ans_pulse", int'({ans_ok, ans_err}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ans_ok",  int'(ans_ok),  int'(e.ok));
                check("ans_err", int'(ans_err), int'(!e.ok));
                check("level_after_ans",  int'(level),  int'(e.lvl));
                check("done_after_ans",   int'(done),   int'(e.dn));
                check("fail_after_ans",   int'(fail),   int'(e.fl));
                check("result_after_ans", int'(result), int'(e.res));
                check("show_low_on_ans",  int'(show),   0);
            end
        end
        if (!sys_rst && show && !prev_show)
            check("dir_from_lfsr", int'(dir), int'(m_prev[1:0]));
        prev_show = show;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic model_restart();
        m_level = START; m_up = 0; m_down = 0; m_done = 0; m_fail = 0; m_result = 0;
    endtask

    task automatic model_answer(input bit correct);
        exp_t e;
        if (m_done) return;
        if (correct) begin
            if (m_down)            begin m_done = 1; m_result = m_level; end
            else if (m_level == 6) begin m_done = 1; m_result = 6; end
            else                   begin m_level++; m_up = 1; end
        end else begin
            if (m_up)              begin m_done = 1; m_result = m_level - 1; end
            else if (m_level == 0) begin m_done = 1; m_fail = 1; end
            else                   begin m_level--; m_down = 1; end
        end
        e.ok = correct; e.lvl = 3'(m_level); e.dn = m_done; e.fl = m_fail; e.res = 3'(m_result);
        sb.push_back(e);
    endtask

    task automatic press(input logic r, input logic [3:0] k);
        key_restart = r;
        keys = k;
        tick(1);
        key_restart = 1'b0;
        keys = 4'd0;
        tick(3);
    endtask

    task automatic wait_show();
        int n = 0;
        while (!show && n < 200) begin tick(1); n++; end
        check("show_reached", int'(show), 1);
    endtask

    task automatic restart();
        model_restart();
        press(1'b1, 4'd0);
    endtask

    task automatic answer(input bit correct, input int delay);
        logic [1:0] d;
        wait_show();
        tick(delay);
        d = correct ? dir : (dir ^ 2'd1);
        model_answer(correct);
        press(1'b0, 4'd1 << d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_show"},   int'(show),    0);
        check({tag, "_dir"},    int'(dir),     0);
        check({tag, "_level"},  int'(level),   START);
        check({tag, "_done"},   int'(done),    0);
        check({tag, "_fail"},   int'(fail),    0);
        check({tag, "_result"}, int'(result),  0);
        check({tag, "_ans"},    int'({ans_ok, ans_err}), 0);
    endtask

    task automatic check_final(input string tag);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_fail"}, int'(fail), int'(m_fail));
        if (!m_fail) check({tag, "_result"}, int'(result), m_result);
    endtask

    initial begin
        model_restart();
        tick(3);
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        tick(2);
        press(1'b0, 4'b0001);
        check("idle_show", int'(show), 0);

        // Always wrong: 4 -> 0 then fail
        restart();
        for (int i = 0; i < 5; i++) answer(1'b0, $urandom_range(0, 10));
        check_final("always_wrong");

        // Wrong, wrong, right -> 0.4
        restart();
        answer(1'b0, 0); answer(1'b0, 3); answer(1'b1, 7);
        check_final("wrong_then_right");

        // Always right -> 1.2; a further key in DONE yields nothing
        restart();
        for (int i = 0; i < 3; i++) answer(1'b1, $urandom_range(0, 10));
        press(1'b0, 4'd1 << dir);
        check_final("always_right");

        // Right, right, wrong -> 1.0
        restart();
        answer(1'b1, 2); answer(1'b1, 0); answer(1'b0, 5);
        check_final("right_then_wrong");

        // Timeout counts as wrong
        restart();
        wait_show();
        model_answer(1'b0);
        tick(TO + 5);
        check("timeout_level", int'(level), 3);

        // Two simultaneous answer keys are ignored
        restart();
        wait_show();
        press(1'b0, 4'b0011);
        check("dual_key_show", int'(show), 1);
        check("dual_key_level", int'(level), START);

        // Correct answer, then a key inside the blank window
        model_answer(1'b1);
        keys = 4'd1 << dir;
        tick(1);
        keys = 4'd0;
        tick(1);
        keys = 4'b0100;
        tick(1);
        keys = 4'd0;
        tick(1);
        check("blank_key_show", int'(show), 0);
        tick(BLANK);
        check("blank_key_show_after", int'(show), 1);
        check("blank_key_level", int'(level), 5);

        // Restart together with an answer mid-SHOW
        model_restart();
        press(1'b1, 4'd1 << dir);
        check("restart_ans_level", int'(level), START);
        check("restart_ans_show", int'(show), 0);
        answer(1'b0, 1);
        check("restart_cleared_flags", int'(level), 3);

        // Synchronous reset mid-test
        restart();
        answer(1'b0, 0);
        wait_show();
        sys_rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        sys_rst = 1'b0;
        model_restart();
        tick(2);

        // Randomised runs to completion
        for (int r = 0; r < 6; r++) begin
            restart();
            while (!m_done) answer(1'($urandom_range(0, 1)), $urandom_range(0, 10));
            check_final("random_run");
        end

        tick(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
